pwm_duty_ramp_ctrl: RTL and testbench
=====================================

// Module: pwm_duty_ramp_ctrl
// PURPOSE
//  Soft-start/soft-stop duty sequencer driving the duty input of the 11-bit PWM generator.
//  - Accepts a target duty over a valid/ready handshake.
//  - Ramps its duty output toward the target in fixed steps, at most one step per
//    PWM_PER_STEP PWM periods.
//  - Changes duty only on a PWM period boundary, so the PWM generator never sees a
//    mid-period change.
//  - Forces duty to 0 immediately on a fault input.
//  Sits between the motor/drive control logic and the PWM generator.
// PARAMETERS
//  STEP          11'd16    duty increment/decrement per ramp step (1..2047)
//  PWM_PER_STEP  4         PWM periods (2048 clks each) between ramp steps (1..255)
//  MAX_DUTY      11'd2000  target ceiling; used only when DUTY_CLAMP_EN is defined
// PORTS
//  clk           in   1   system clock, same clock as the PWM generator
//  rst_n         in   1   asynchronous active-low reset
//  tgt_duty      in   11  requested target duty, unsigned
//  tgt_vld       in   1   tgt_duty valid
//  tgt_rdy       out  1   target can be accepted (= state != FAULT)
//  fault         in   1   overcurrent/fault request, level, synchronous to clk
//  clr_fault     in   1   clear sticky fault, single-cycle pulse
//  duty          out  11  registered duty to the PWM generator
//  period_start  out  1   high in the cycle pcnt==11'h7FF (last clk of a PWM period)
//  busy          out  1   high while state==RAMP
//  fault_sticky  out  1   high while state==FAULT
// BEHAVIOUR
//  Reset values:
//  - duty=0, pcnt=0, scnt=0, tgt_q=0, state=IDLE.
//  - Outputs after reset: busy=0, fault_sticky=0, period_start=0, tgt_rdy=1.
//  - rst_n low mid-ramp or mid-fault returns everything to these values asynchronously.
//  Period counter:
//  - pcnt is 11-bit, increments every clk, wraps 2047->0.
//  - Reset-aligned with the PWM generator's counter.
//  - Boundary edge = the clk edge at which pcnt goes 7FF->0.
//  Handshake:
//  - Accept when tgt_vld && tgt_rdy; tgt_q <= tgt_duty at that edge.
//  - A new target may be accepted in IDLE or RAMP and replaces tgt_q.
//  - In FAULT, tgt_vld is ignored.
//  States:
//  - IDLE: duty==tgt_q. An accept with tgt_duty!=duty -> RAMP, scnt<=0.
//    Equal target: stay IDLE.
//  - RAMP: scnt counts boundary edges.
//    - On the boundary edge with scnt==PWM_PER_STEP-1, scnt<=0 and duty moves toward tgt_q:
//      - up:   duty <= (tgt_q-duty <= STEP) ? tgt_q : duty+STEP
//      - down: duty <= (duty-tgt_q <= STEP) ? tgt_q : duty-STEP
//    - Arithmetic is 12-bit; no overshoot, no wrap past 0 or 2047.
//    - When the updated duty equals tgt_q -> IDLE on the same edge.
//    - First step occurs PWM_PER_STEP boundaries after entering RAMP.
//  - FAULT: entered on any clk edge with fault==1, from any state and not boundary-aligned.
//    - duty<=0 and tgt_q<=0 on that edge.
//    - Leave to IDLE when clr_fault==1 && fault==0; duty stays 0.
//  Simultaneous events:
//  - fault beats accept, step and clr_fault.
//  - Accept on a step edge: the step uses the old tgt_q; the new tgt_q applies from the
//    next step.
//  - Retarget in RAMP equal to the current duty: -> IDLE on the next edge.
//  - Retarget that reverses direction: ramp reverses; scnt is not cleared.
//  - duty never changes except on a boundary edge, a fault edge or reset.
// CONFIGURATION
//  DUTY_CLAMP_EN defined:
//  - Accepted target is clamped: tgt_q <= min(tgt_duty, MAX_DUTY).
//  - duty never exceeds MAX_DUTY.
//  DUTY_CLAMP_EN undefined:
//  - tgt_q <= tgt_duty unmodified.
//  - MAX_DUTY has no effect.
// TESTING (STEP=16, PWM_PER_STEP=4)
//  1. Reset, accept 64 at clk 10 -> duty 16/32/48/64 at boundaries 4/8/12/16;
//     busy 1 until the edge duty=64, then 0.
//  2. From IDLE duty=64, accept 40 -> duty 48 at boundary 4, then 40 at boundary 8
//     (saturates, no 32); busy 0 after.
//  3. Fault=1 mid-ramp at duty=32 -> duty=0 and fault_sticky=1 next edge; tgt_rdy=0,
//     tgt_vld ignored; clr_fault with fault=1 ignored; clr_fault with fault=0 -> IDLE,
//     tgt_rdy=1, duty 0.
//  4. Accept 128 on the same edge as a step 16->32 -> duty=32; next step 48; ramp
//     continues to 128.
//  5. Accept 2047: with DUTY_CLAMP_EN duty stops at 2000 (1984->2000); without it,
//     duty goes 2032->2047.
//  6. Throughout 1-5, duty transitions occur only on edges where pcnt wraps 7FF->0,
//     except fault and reset.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl.sv
// Soft-start/soft-stop duty sequencer for the 11-bit PWM generator; steps duty toward the target
// only on PWM period boundaries. Define DUTY_CLAMP_EN to clamp accepted targets to MAX_DUTY.
module pwm_duty_ramp_ctrl #(
  parameter logic [10:0] STEP         = 11'd16,
  parameter int unsigned PWM_PER_STEP = 4,
  parameter logic [10:0] MAX_DUTY     = 11'd2000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] tgt_duty,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  input  logic        fault,
  input  logic        clr_fault,
  output logic [10:0] duty,
  output logic        period_start,
  output logic        busy,
  output logic        fault_sticky
);

  typedef enum logic [1:0] {StIdle, StRamp, StFault} state_e;

  localparam logic [7:0] LastScnt = 8'(PWM_PER_STEP - 1);

  state_e      state_q, state_d;
  logic [10:0] pcnt_q;
  logic [10:0] duty_q, duty_d;
  logic [10:0] tgt_q, tgt_d;
  logic [7:0]  scnt_q, scnt_d;
  logic [10:0] tgt_in;
  logic [11:0] up_gap, dn_gap;
  logic [10:0] ramp_duty;
  logic        boundary, step_edge, accept;

`ifdef DUTY_CLAMP_EN
  assign tgt_in = (tgt_duty > MAX_DUTY) ? MAX_DUTY : tgt_duty;
`else
  logic unused_max_duty;
  assign unused_max_duty = ^MAX_DUTY;
  assign tgt_in          = tgt_duty;
`endif

  // Last clk of a PWM period; the following edge is the boundary edge.
  assign boundary  = (pcnt_q == 11'h7FF);
  assign step_edge = boundary && (scnt_q == LastScnt);
  assign accept    = tgt_vld && tgt_rdy;

  // 12-bit gaps so the saturation test can never wrap.
  assign up_gap = {1'b0, tgt_q} - {1'b0, duty_q};
  assign dn_gap = {1'b0, duty_q} - {1'b0, tgt_q};

  always_comb begin
    ramp_duty = duty_q;
    if (tgt_q > duty_q) begin
      ramp_duty = (up_gap <= {1'b0, STEP}) ? tgt_q : 11'({1'b0, duty_q} + {1'b0, STEP});
    end else begin
      ramp_duty = (dn_gap <= {1'b0, STEP}) ? tgt_q : 11'({1'b0, duty_q} - {1'b0, STEP});
    end
  end

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    scnt_d  = scnt_q;
    if (fault) begin
      state_d = StFault;
      duty_d  = '0;
      tgt_d   = '0;
      scnt_d  = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            tgt_d = tgt_in;
            if (tgt_in != duty_q) begin
              state_d = StRamp;
              scnt_d  = '0;
            end
          end
        end
        StRamp: begin
          if (step_edge) begin
            scnt_d = '0;
            duty_d = ramp_duty;
          end else if (boundary) begin
            scnt_d = scnt_q + 8'd1;
          end
          // A step on the accept edge still uses the old target.
          if (accept) tgt_d = tgt_in;
          if (duty_d == tgt_d) state_d = StIdle;
        end
        StFault: begin
          if (clr_fault) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pcnt_q  <= '0;
      duty_q  <= '0;
      tgt_q   <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_q + 11'd1;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign tgt_rdy      = (state_q != StFault);
  assign duty         = duty_q;
  assign period_start = boundary;
  assign busy         = (state_q == StRamp);
  assign fault_sticky = (state_q == StFault);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Randomized self-checking bench for pwm_duty_ramp_ctrl against a cycle-level behavioural model.
// Uses a large STEP and short PWM_PER_STEP so full-scale ramps fit a short run.
module tb_pwm_duty_ramp_ctrl;

  localparam logic [10:0] STEP     = 11'd500;
  localparam int unsigned PPS      = 2;
  localparam logic [10:0] MAX_DUTY = 11'd2000;
  localparam int          PERIOD   = 2048;
  localparam int          MIdle    = 0;
  localparam int          MRamp    = 1;
  localparam int          MFault   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] tgt_duty;
  logic        tgt_vld;
  logic        tgt_rdy;
  logic        fault;
  logic        clr_fault;
  logic [10:0] duty;
  logic        period_start;
  logic        busy;
  logic        fault_sticky;

  int n_checks = 0;
  int n_fail   = 0;
  int cur      = 0;

  int m_cyc  = 0;
  int m_duty = 0;
  int m_tgt  = 0;
  int m_mode = MIdle;
  int m_nb   = 0;

  pwm_duty_ramp_ctrl #(
    .STEP        (STEP),
    .PWM_PER_STEP(PPS),
    .MAX_DUTY    (MAX_DUTY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tgt_duty    (tgt_duty),
    .tgt_vld     (tgt_vld),
    .tgt_rdy     (tgt_rdy),
    .fault       (fault),
    .clr_fault   (clr_fault),
    .duty        (duty),
    .period_start(period_start),
    .busy        (busy),
    .fault_sticky(fault_sticky)
  );

  always #5 clk = ~clk;

  function automatic int clamp_tgt(int t);
`ifdef DUTY_CLAMP_EN
    return (t > int'(MAX_DUTY)) ? int'(MAX_DUTY) : t;
`else
    return t;
`endif
  endfunction

  function automatic int step_toward(int d, int t);
    if (t > d) return (d + int'(STEP) < t) ? d + int'(STEP) : t;
    return (d - int'(STEP) > t) ? d - int'(STEP) : t;
  endfunction

  function automatic logic [14:0] exp_vec();
    return {11'(m_duty), m_mode == MRamp, m_mode == MFault, m_mode != MFault,
            (m_cyc % PERIOD) == PERIOD - 1};
  endfunction

  function automatic logic [14:0] obs();
    return {duty, busy, fault_sticky, tgt_rdy, period_start};
  endfunction

  // Model: time measured in clocks since reset; m_nb counts boundaries since the ramp began.
  always @(posedge clk or negedge rst_n) begin : model
    int  nd;
    int  nt;
    bit  bnd;
    if (!rst_n) begin
      m_cyc  <= 0;
      m_duty <= 0;
      m_tgt  <= 0;
      m_mode <= MIdle;
      m_nb   <= 0;
    end else begin
      bnd = (m_cyc % PERIOD) == PERIOD - 1;
      m_cyc <= m_cyc + 1;
      if (fault) begin
        m_mode <= MFault;
        m_duty <= 0;
        m_tgt  <= 0;
      end else if (m_mode == MFault) begin
        if (clr_fault) m_mode <= MIdle;
      end else begin
        nd = m_duty;
        nt = m_tgt;
        if (tgt_vld) nt = clamp_tgt(int'(tgt_duty));
        if (m_mode == MRamp && bnd) begin
          m_nb <= m_nb + 1;
          if ((m_nb + 1) % PPS == 0) nd = step_toward(m_duty, m_tgt);
        end
        if (m_mode == MIdle) m_nb <= 0;
        m_duty <= nd;
        m_tgt  <= nt;
        m_mode <= (nd == nt) ? MIdle : MRamp;
      end
    end
  end

  task automatic accept(input int v);
    tgt_duty = 11'(v);
    tgt_vld  = 1'b1;
    @(negedge clk);
    tgt_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs() !== {11'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values got=%h want=%h", obs(), {11'd0, 4'b0010});
    end
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
    end
  endtask

  task automatic test_ramp_up();
    int t;
    int nb;
    bit ok;
    t  = $urandom_range(1400, 600);
    nb = 0;
    ok = 0;
    accept(t);
    for (int i = 0; i < 8 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL ramp_up t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (duty == 11'd0 && (m_cyc % PERIOD) == PERIOD - 1) nb++;
      if (duty != 11'd0 && nb >= 0) begin
        n_checks++;
        if (nb != int'(PPS)) begin
          n_fail++;
          $display("FAIL first_step_delay got=%0d boundaries want=%0d", nb, PPS);
        end
        nb = -1;
      end
      if (m_mode == MIdle) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok || duty !== 11'(t) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_up_end done=%0d duty=%0d busy=%b want duty=%0d busy=0",
               ok, duty, busy, t);
    end
    cur = t;
  endtask

  task automatic test_ramp_down();
    int t;
    int lo;
    bit ok;
    lo = (cur > 1100) ? cur - 1100 : 0;
    t  = $urandom_range(cur - 1, lo);
    ok = 0;
    accept(t);
    for (int i = 0; i < 8 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL ramp_down t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (m_mode == MIdle) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok || duty !== 11'(t)) begin
      n_fail++;
      $display("FAIL ramp_down_end done=%0d duty=%0d want=%0d", ok, duty, t);
    end
    accept(t);
    n_checks++;
    if (busy !== 1'b0 || duty !== 11'(t)) begin
      n_fail++;
      $display("FAIL equal_target busy=%b duty=%0d want busy=0 duty=%0d", busy, duty, t);
    end
    cur = t;
  endtask

  task automatic test_fault();
    int w;
    accept(1900);
    w = $urandom_range(1500, 1);
    for (int i = 0; i < 4 * PERIOD + w; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL fault_pre t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (i > w && duty != 11'(cur)) break;
    end
    fault = 1'b1;
    @(negedge clk);
    n_checks++;
    if (duty !== 11'd0 || fault_sticky !== 1'b1 || tgt_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_entry duty=%0d sticky=%b rdy=%b want 0/1/0", duty, fault_sticky,
               tgt_rdy);
    end
    tgt_vld   = 1'b1;
    tgt_duty  = 11'($urandom_range(2047, 1));
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    fault     = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs() !== exp_vec() || fault_sticky !== 1'b1 || duty !== 11'd0) begin
      n_fail++;
      $display("FAIL fault_hold got=%h want sticky=1 duty=0 (%h)", obs(), exp_vec());
    end
    tgt_vld   = 1'b0;
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    n_checks++;
    if (tgt_rdy !== 1'b1 || fault_sticky !== 1'b0 || duty !== 11'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear rdy=%b sticky=%b duty=%0d busy=%b want 1/0/0/0", tgt_rdy,
               fault_sticky, duty, busy);
    end
    cur = 0;
  endtask

  task automatic test_retarget();
    int  t2;
    bit  ok;
    accept(1500);
    ok = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL retarget_pre t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (m_mode == MRamp && (m_cyc % PERIOD) == PERIOD - 1 && (m_nb + 1) % int'(PPS) == 0) begin
        ok = 1;
        break;
      end
    end
    t2 = $urandom_range(1900, 1600);
    accept(t2);
    n_checks++;
    if (!ok || duty !== STEP || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_on_step found=%0d duty=%0d busy=%b want duty=%0d busy=1", ok, duty,
               busy, STEP);
    end
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL retarget_up t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (duty >= 11'd1000) break;
    end
    repeat ($urandom_range(1000, 1)) @(negedge clk);
    accept(200);
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL reverse t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (duty != 11'd1000) break;
    end
    n_checks++;
    if (duty !== 11'd500) begin
      n_fail++;
      $display("FAIL reverse_step duty=%0d want=500", duty);
    end
    repeat ($urandom_range(500, 1)) @(negedge clk);
    accept(500);
    n_checks++;
    if (busy !== 1'b0 || duty !== 11'd500) begin
      n_fail++;
      $display("FAIL retarget_equal busy=%b duty=%0d want busy=0 duty=500", busy, duty);
    end
    cur = 500;
  endtask

  task automatic test_reset_mid_ramp();
    accept(1800);
    for (int i = 0; i < 3 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_ramp t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      if (duty != 11'(cur)) break;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs() !== {11'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=%h", obs(), {11'd0, 4'b0010});
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur   = 0;
  endtask

  task automatic test_full_scale();
    bit ok;
    bit prev_bnd;
    int prev_duty;
    int want;
`ifdef DUTY_CLAMP_EN
    want = 2000;
`else
    want = 2047;
`endif
    ok        = 0;
    prev_bnd  = 0;
    prev_duty = 0;
    accept(2047);
    for (int i = 0; i < 14 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs() !== exp_vec()) begin
        n_fail++;
        $display("FAIL full_scale t=%0t got=%h want=%h", $time, obs(), exp_vec());
      end
      n_checks++;
      if (int'(duty) != prev_duty && !prev_bnd) begin
        n_fail++;
        $display("FAIL off_boundary t=%0t duty=%0d prev=%0d want change only at boundary",
                 $time, duty, prev_duty);
      end
      prev_duty = int'(duty);
      prev_bnd  = (m_cyc % PERIOD) == PERIOD - 1;
      if (m_mode == MIdle) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok || duty !== 11'(want) || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_scale_end done=%0d duty=%0d busy=%b want duty=%0d", ok, duty, busy,
               want);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tgt_duty  = '0;
    tgt_vld   = 1'b0;
    fault     = 1'b0;
    clr_fault = 1'b0;
    @(negedge clk);
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_fault();
    test_retarget();
    test_reset_mid_ramp();
    test_full_scale();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
